// File: rtl/change_log_pkg.sv
// change_log_pkg: shared defaults and occupancy-width helper for the change event logger
package change_log_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int TS_W_DEF = 16;
  localparam int DEPTH_DEF = 8;
  localparam int DROP_W = 8;
  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO; head data reads as 0 when empty
module sync_fifo_fwft import change_log_pkg::*; #(
  parameter int DW = 24,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DW-1:0]             din,
  output logic [DW-1:0]             dout,
  output logic                      full,
  output logic                      empty,
  output logic [occ_w(DEPTH)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign count = wr_ptr - rd_ptr;
  // occupancy never exceeds 2^AW, so the top bit alone marks full
  assign full = count[AW];
  assign empty = ~|count;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
endmodule

// File: rtl/change_event_logger.sv
// change_event_logger: records {timestamp, old, new} for each change of sig_in into a FIFO.
// Define CHANGE_EVENT_LOGGER_DROPCNT_EN to add the saturating drop_cnt output.
module change_event_logger import change_log_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TS_W = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [WIDTH-1:0]          sig_in,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [TS_W-1:0]           evt_time,
  output logic [WIDTH-1:0]          evt_old,
  output logic [WIDTH-1:0]          evt_new,
  output logic [occ_w(DEPTH)-1:0]   evt_count,
  output logic                      overflow
`ifdef CHANGE_EVENT_LOGGER_DROPCNT_EN
  ,
  output logic [DROP_W-1:0]         drop_cnt
`endif
);
  logic [TS_W-1:0] ts;
  logic [WIDTH-1:0] last;
  logic primed, push, pop, drop, full, empty;
  logic [TS_W+2*WIDTH-1:0] head;
  assign push = primed && en && (sig_in != last);
  assign pop = evt_valid && evt_ready;
  assign drop = push && full && !pop;
  assign evt_valid = !empty;
  assign {evt_time, evt_old, evt_new} = head;
  sync_fifo_fwft #(.DW(TS_W + 2*WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
    .din({ts, last, sig_in}), .dout(head),
    .full(full), .empty(empty), .count(evt_count)
  );
  // last tracks sig_in even when disabled so re-enabling never reports stale changes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ts <= '0;
      last <= '0;
      primed <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      last <= sig_in;
      primed <= 1'b1;
    end
`ifdef CHANGE_EVENT_LOGGER_DROPCNT_EN
  assign overflow = |drop_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_cnt <= '0;
    else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
`endif
endmodule

// File: doc/change_event_logger.md
Name: change_event_logger

Overview:
- Monitors a multi-bit signal every clock, detects value changes and records each change as an event {timestamp, old value, new value}.
- Events are buffered in a small FIFO and drained through a valid/ready interface.
- Upstream: the stimulus or driver logic that modifies the watched signal. Downstream: a scoreboard, logger or trace port.
- It is the clocked hardware equivalent of an "@(signal) display change" monitor.

Parameters:
- WIDTH, 4, width of the watched signal.
- TS_W, 16, width of the free-running timestamp counter.
- DEPTH, 8, number of FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  change detection enable.
- sig_in  in  WIDTH  the watched signal.
- evt_valid  out  1  the FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head event.
- evt_time  out  TS_W  timestamp of the head event.
- evt_old  out  WIDTH  value before the change.
- evt_new  out  WIDTH  value after the change.
- evt_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: at least one event was dropped.

Behaviour:
- Reset (asynchronous assert, synchronous effect on deassert):
  - Clears ts, last, primed, FIFO pointers, overflow and the drop counter.
  - All outputs are 0.
  - Reset asserted mid-operation discards all queued events immediately.
- Timestamp: ts increments by 1 on every edge and wraps modulo 2^TS_W. The first edge after reset release sees ts=0.
- Priming: on the first edge after reset, last<=sig_in and primed<=1. No event is generated on that edge.
- Detection, on each edge with primed=1:
  - If en=1 and sig_in!=last, push the event {ts, last, sig_in}.
  - last<=sig_in on every edge, whether or not en is set, so re-enabling never reports stale changes.
- Latency: an event pushed at edge k is visible as evt_valid=1 from edge k onward, i.e. one cycle after sig_in settled before edge k.
- Handshake:
  - The head event pops on an edge where evt_valid && evt_ready.
  - evt_time, evt_old and evt_new must stay stable while evt_valid=1 and evt_ready=0.
  - evt_time, evt_old and evt_new are 0 whenever evt_valid=0.
- Full FIFO:
  - A push with no simultaneous pop is dropped; overflow<=1 and stays 1 until reset.
  - A push with a simultaneous pop is accepted, and occupancy stays at DEPTH.
- Empty FIFO: there is no same-cycle bypass; a push on an empty FIFO appears at the next edge per the latency rule.
- Simultaneous push and pop on a non-empty, non-full FIFO: occupancy is unchanged.
- evt_count ranges 0..DEPTH.

Optional Feature:
- Macro: CHANGE_EVENT_LOGGER_DROPCNT_EN.
- When defined:
  - Adds the output port drop_cnt (8 bits): a saturating count of dropped events, reset to 0, holding at 255.
  - overflow equals (drop_cnt!=0).
- When undefined: no drop_cnt port and no counter; only the sticky overflow flag exists.

Decomposition:
- Package change_log_pkg:
  - Default localparams: WIDTH_DEF=4, TS_W_DEF=16, DEPTH_DEF=8, DROP_W=8.
  - A helper function computing occupancy width.
- Sub-module sync_fifo_fwft:
  - Parameterized by data width (TS_W+2*WIDTH) and DEPTH.
  - Provides push/pop/full/empty/count, with rst_n and clk named identically.
- The top level holds the ts counter, last register, prime flag, change comparator and overflow logic.

Test Plan:
- Basic capture: reset, hold sig_in=0 with evt_ready=0 and en=1; drive 4 before edge 3 and 2 before edge 5. Expect events (ts3, 0→4) and (ts5, 4→2), evt_count=2, and head stable until evt_ready=1.
- Prime/disable: sig_in=7 during reset, so no event at the first edge. With en=0, change sig_in to 9, then set en=1 with no further change. Expect no event ever.
- Overflow: DEPTH=8, evt_ready=0, toggle sig_in 0/1 every edge for 10 changes.
  - Expect evt_count=8 and overflow=1; the 9th and 10th changes are lost.
  - With CHANGE_EVENT_LOGGER_DROPCNT_EN defined, expect drop_cnt=2.
- Full with concurrent pop: FIFO full, evt_ready=1 and a change on the same edge. Expect the event accepted, count stays 8 and overflow stays 0.
- Reset mid-operation: assert rst_n=0 between edges with 3 queued events. Expect evt_valid=0, evt_count=0 and overflow=0 immediately, before the next edge.
- Timestamp wrap: TS_W=4, change sig_in at cycle 17. Expect evt_time=1.
